// File: rtl/ahb_wait_mem.sv
// ---------------------------------------------------------------------------
// ahb_wait_mem
//
// AHB-Lite memory slave. Every OKAY transfer gets WAIT_STATES low-HREADYOUT
// cycles and then one completing cycle. Malformed or out-of-range transfers
// get the two-cycle ERROR response and never touch memory. Writes are
// byte-lane masked (little-endian). Read data is 0 outside a read's final
// data-phase cycle.
//
// Ports
//   HCLK       clock, all state changes on the rising edge
//   HRST       synchronous active-high reset
//   HSEL       slave select
//   HADDR      transfer address (byte address)
//   HWRITE     1 = write, 0 = read
//   HSIZE      0 byte, 1 half, 2 word; larger sizes are errors
//   HBURST     burst type; accepted but ignored (each beat stands alone)
//   HTRANS     IDLE/BUSY/NONSEQ/SEQ; only NONSEQ/SEQ start a transfer
//   HREADY     bus ready; qualifies address-phase sampling
//   HWDATA     write data, valid in the data phase
//   HREADYOUT  data phase complete
//   HRESP      0 OKAY, 1 ERROR
//   HRDATA     read data
// ---------------------------------------------------------------------------
module ahb_wait_mem #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 32,
  parameter int MEM_DEPTH    = 256,
  parameter int WAIT_STATES  = 1,
  parameter int HBURST_WIDTH = 3
) (
  input  logic                    HCLK,
  input  logic                    HRST,
  input  logic                    HSEL,
  input  logic [ADDR_WIDTH-1:0]   HADDR,
  input  logic                    HWRITE,
  input  logic [2:0]              HSIZE,
  input  logic [HBURST_WIDTH-1:0] HBURST,
  input  logic [1:0]              HTRANS,
  input  logic                    HREADY,
  input  logic [DATA_WIDTH-1:0]   HWDATA,
  output logic                    HREADYOUT,
  output logic                    HRESP,
  output logic [DATA_WIDTH-1:0]   HRDATA
);

  localparam int LANES = DATA_WIDTH / 8;
  localparam int IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam logic [ADDR_WIDTH-3:0] DEPTH_WORDS = (ADDR_WIDTH-2)'(MEM_DEPTH);
  localparam logic [3:0] WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_DATA,
    ST_ERR1,
    ST_ERR2
  } state_t;

  state_t                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [IDX_W+1:0]      addr_q, addr_d;
  logic                  write_q, write_d;
  logic [1:0]            size_q, size_d;
  logic [LANES-1:0]      fwd_mask_q, fwd_mask_d;
  logic [DATA_WIDTH-1:0] fwd_data_q, fwd_data_d;

  logic                  slot_open;
  logic                  accept;
  logic                  addr_err;
  logic                  commit;
  logic [LANES-1:0]      lane_en;
  logic [IDX_W-1:0]      wr_idx;
  logic [IDX_W-1:0]      rd_idx;
  logic [DATA_WIDTH-1:0] rd_word_q;
  logic [DATA_WIDTH-1:0] rdata_merged;

  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  // HBURST carries no meaning for this target.
  logic unused_hburst;
  assign unused_hburst = ^HBURST;

  // A new address phase can only be taken in a cycle where our own data
  // phase (if any) is completing.
  assign slot_open = (state_q == ST_IDLE) || (state_q == ST_DATA) || (state_q == ST_ERR2);
  assign accept    = slot_open && HSEL && HREADY && HTRANS[1];

  assign addr_err = (HSIZE > 3'd2)
                 || ((HSIZE == 3'd1) && HADDR[0])
                 || ((HSIZE == 3'd2) && (HADDR[1:0] != 2'b00))
                 || (HADDR[ADDR_WIDTH-1:2] >= DEPTH_WORDS);

  // ------------------------------------------------------------------
  // Next-state logic
  // ------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    write_d = write_q;
    size_d  = size_q;

    if (accept) begin
      addr_d  = HADDR[IDX_W+1:0];
      write_d = HWRITE;
      size_d  = HSIZE[1:0];
    end

    case (state_q)
      ST_IDLE, ST_DATA, ST_ERR2: begin
        if (accept) begin
          if (addr_err) begin
            state_d = ST_ERR1;
          end else if (WAIT_STATES > 0) begin
            state_d = ST_WAIT;
            cnt_d   = WAIT_LOAD;
          end else begin
            state_d = ST_DATA;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = ST_DATA;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_ERR1: state_d = ST_ERR2;
      default: state_d = ST_IDLE;
    endcase
  end

  // ------------------------------------------------------------------
  // Write lanes and read forwarding
  // ------------------------------------------------------------------
  // The write commits on the edge that ends DATA; a reset on that same edge
  // abandons it.
  assign commit = (state_q == ST_DATA) && write_q && !HRST;
  assign wr_idx = addr_q[IDX_W+1:2];

  // The read word is captured on the edge entering DATA. With zero wait
  // states that edge is also the acceptance edge, so the live address is
  // used; otherwise the registered address is.
  assign rd_idx = accept ? HADDR[IDX_W+1:2] : addr_q[IDX_W+1:2];

  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    localparam logic [1:0] LANE = 2'(gi);
    assign lane_en[gi] = (size_q == 2'd2)
                      || ((size_q == 2'd1) && (addr_q[1] == LANE[1]))
                      || ((size_q == 2'd0) && (addr_q[1:0] == LANE));
    // Lanes written on the same edge the read word was captured come from
    // the forwarding register, since the memory read returned the old word.
    assign rdata_merged[8*gi +: 8] = fwd_mask_q[gi] ? fwd_data_q[8*gi +: 8]
                                                    : rd_word_q[8*gi +: 8];
  end

  always_comb begin
    fwd_mask_d = '0;
    fwd_data_d = HWDATA;
    if (commit && (wr_idx == rd_idx)) begin
      fwd_mask_d = lane_en;
    end
  end

  // Block RAM: byte-enabled write port, registered read port, no reset.
  always_ff @(posedge HCLK) begin
    for (int b = 0; b < LANES; b++) begin
      if (commit && lane_en[b]) begin
        mem[wr_idx][8*b +: 8] <= HWDATA[8*b +: 8];
      end
    end
    rd_word_q <= mem[rd_idx];
  end

  // ------------------------------------------------------------------
  // State registers
  // ------------------------------------------------------------------
  always_ff @(posedge HCLK) begin
    if (HRST) begin
      state_q    <= ST_IDLE;
      cnt_q      <= 4'd0;
      addr_q     <= '0;
      write_q    <= 1'b0;
      size_q     <= 2'd0;
      fwd_mask_q <= '0;
      fwd_data_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      write_q    <= write_d;
      size_q     <= size_d;
      fwd_mask_q <= fwd_mask_d;
      fwd_data_q <= fwd_data_d;
    end
  end

  // ------------------------------------------------------------------
  // Outputs
  // ------------------------------------------------------------------
  assign HREADYOUT = (state_q == ST_IDLE) || (state_q == ST_DATA) || (state_q == ST_ERR2);
  assign HRESP     = (state_q == ST_ERR1) || (state_q == ST_ERR2);
  assign HRDATA    = ((state_q == ST_DATA) && !write_q) ? rdata_merged : '0;

endmodule

// File: doc/ahb_wait_mem.md
# ahb_wait_mem

AHB-Lite memory slave with a configurable number of wait states, byte-lane writes and two-cycle ERROR responses. It sits directly downstream of the bus master's address/data outputs and returns HREADYOUT/HRESP/HRDATA to it. It exercises the master's wait-state and error-handling paths against a deterministic target.

## Interface
- DATA_WIDTH, 32, data bus width; fixed at 32 for this block.
- ADDR_WIDTH, 32, address bus width.
- MEM_DEPTH, 256, number of 32-bit words; byte address range 0 .. 4*MEM_DEPTH-1.
- WAIT_STATES, 1, HREADYOUT-low cycles inserted before each OKAY data phase completes (0..15).
- HBURST_WIDTH, 3, HBURST width.

Ports:
- HCLK  in  1  single clock; all state updates on the rising edge.
- HRST  in  1  reset, synchronous and active-high.
- HSEL  in  1  slave select.
- HADDR  in  ADDR_WIDTH  transfer address.
- HWRITE  in  1  1 = write, 0 = read.
- HSIZE  in  3  transfer size: 0 = byte, 1 = half, 2 = word.
- HBURST  in  HBURST_WIDTH  burst type; accepted, not interpreted.
- HTRANS  in  2  0 IDLE, 1 BUSY, 2 NONSEQ, 3 SEQ.
- HREADY  in  1  bus ready; qualifies address-phase sampling.
- HWDATA  in  DATA_WIDTH  write data, valid in the data phase.
- HREADYOUT  out  1  data phase complete.
- HRESP  out  1  0 OKAY, 1 ERROR.
- HRDATA  out  DATA_WIDTH  read data.

## Operation
- Address phase is accepted on an edge with HSEL=1, HREADY=1 and HTRANS[1]=1. On acceptance, HADDR, HWRITE and HSIZE are registered.
- IDLE, BUSY, or HSEL=0 with HREADY=1: no transfer. The next cycle is a zero-wait OKAY.
- Error check runs at acceptance. An error is raised for any of:
  - HSIZE > 2;
  - misalignment (half with HADDR[0]=1; word with HADDR[1:0]≠0);
  - HADDR[ADDR_WIDTH-1:2] ≥ MEM_DEPTH.
- States:
  - IDLE: HREADYOUT=1, HRESP=0.
  - WAIT: HREADYOUT=0, HRESP=0. Counter loads WAIT_STATES-1 and decrements; at 0, go to DATA.
  - DATA: HREADYOUT=1, HRESP=0. Write commits or read data is driven.
  - ERR1: HREADYOUT=0, HRESP=1.
  - ERR2: HREADYOUT=1, HRESP=1.
- Transitions on an accepted transfer:
  - From IDLE or DATA: to ERR1 on error, else to WAIT if WAIT_STATES>0, else to DATA.
  - From ERR2: same as IDLE.
  - From DATA or ERR2 with no accepted transfer: to IDLE.
  - ERR1 always goes to ERR2.
- Writes:
  - Lanes are little-endian. Byte writes lane HADDR[1:0], half writes lanes {HADDR[1],0}+0/1, word writes all four lanes.
  - Data comes from HWDATA in DATA and is committed at the edge ending DATA.
  - Other lanes are unchanged. An erroring write never modifies memory.
- Reads: HRDATA = full word at the registered address, held stable during DATA. HRDATA = 0 in all other states.
- HBURST is ignored. Each beat is checked and served independently by its own address.
- Memory is not cleared by reset. Contents are undefined until written.

## Timing
- Reset values: HREADYOUT=1, HRESP=0, HRDATA=0, state IDLE, wait counter 0.
- Reset mid-transfer: the transfer is abandoned and a pending write is not committed. The first cycle after reset is IDLE.
- OKAY data phase lasts WAIT_STATES+1 cycles, with HREADYOUT high only in the last.
- ERROR data phase is always exactly 2 cycles, independent of WAIT_STATES.
- Pipelining: the next address phase overlaps the final data-phase cycle (DATA or ERR2) only.
- Read-after-write to the same word, back-to-back: the read returns the new value, because the write commits at the edge entering the read's data phase.
- HTRANS changing to IDLE/BUSY while HREADYOUT=0 is not sampled.

## Test plan
- WAIT_STATES=1: word write 0xDEADBEEF to 0x10, then word read 0x10.
  - Each data phase is 2 cycles with HREADYOUT 0 then 1.
  - HRDATA=0xDEADBEEF in the read's final cycle, HRESP=0.
- WAIT_STATES=0: word write 0x11223344 to 0x20, byte write 0xAA to 0x22, half write 0xBEEF to 0x20, then read 0x20.
  - Read returns 0x11AABEEF.
  - Every phase completes in 1 cycle.
- Error cases: word access to 0x02, HSIZE=3 to 0x00, and word access to 0x400 with MEM_DEPTH=256.
  - Each gives HREADYOUT=0/HRESP=1, then HREADYOUT=1/HRESP=1.
  - A read of the target word afterwards shows memory unchanged.
- INCR4 burst of writes 0x0, 0x4, 0x8, 0xC (NONSEQ, SEQ, BUSY, SEQ, SEQ) with WAIT_STATES=2.
  - Each beat takes 3 cycles; the BUSY slot gives a 1-cycle OKAY.
  - Readback matches all four words.
- Assert HRST during WAIT of a write to 0x30 holding 0x55555555.
  - Next cycle: HREADYOUT=1, HRESP=0, HRDATA=0.
  - A later read of 0x30 returns 0x55555555.
